// File: rtl/despachante_chamadas.sv
// rtl/despachante_chamadas.sv - hall-call dispatcher for the four-floor elevator
// Latches call buttons, picks the next floor same-direction-first and times the door.
module despachante_chamadas #(
  parameter int unsigned TEMPO_PORTA = 25_000_000
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic [3:0] botoes_chamada,
  input  logic [1:0] andar_atual,
  output logic [1:0] alvo,
  output logic       alvo_valido,
  output logic [3:0] pendentes,
  output logic       porta_aberta,
  output logic       direcao
);

  localparam logic [24:0] RECARGA = 25'(TEMPO_PORTA - 1);

  typedef enum logic [1:0] {OCIOSO, MOVENDO, PORTA} estado_t;

  estado_t     estado_q, estado_d;
  logic [3:0]  pendentes_q, pendentes_d;
  logic [1:0]  alvo_q, alvo_d;
  logic        valido_q, valido_d;
  logic        direcao_q, direcao_d;
  logic [24:0] cont_q, cont_d;

  logic [3:0]  limpa;
  logic [3:0]  um_hot_atual;
  logic [3:0]  mascara;
  logic        aqui;
  logic        tem_acima, tem_abaixo;
  logic [1:0]  acima, abaixo;

  assign um_hot_atual = 4'b0001 << andar_atual;
  assign aqui         = pendentes_q[andar_atual];

  // Scan direction makes the last hit the nearest pending floor on each side.
  always_comb begin
    tem_acima  = 1'b0;
    acima      = 2'd0;
    tem_abaixo = 1'b0;
    abaixo     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pendentes_q[i] && (2'(i) > andar_atual)) begin
        tem_acima = 1'b1;
        acima     = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pendentes_q[i] && (2'(i) < andar_atual)) begin
        tem_abaixo = 1'b1;
        abaixo     = 2'(i);
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= OCIOSO;
      pendentes_q <= 4'b0000;
      alvo_q      <= 2'd0;
      valido_q    <= 1'b0;
      direcao_q   <= 1'b1;
      cont_q      <= 25'd0;
    end else begin
      estado_q    <= estado_d;
      pendentes_q <= pendentes_d;
      alvo_q      <= alvo_d;
      valido_q    <= valido_d;
      direcao_q   <= direcao_d;
      cont_q      <= cont_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    limpa     = 4'b0000;
    alvo_d    = alvo_q;
    valido_d  = valido_q;
    direcao_d = direcao_q;
    cont_d    = cont_q;
    case (estado_q)
      OCIOSO: begin
        if (pendentes_q != 4'b0000) begin
          if (aqui) begin
            limpa    = um_hot_atual;
            cont_d   = RECARGA;
            estado_d = PORTA;
          end else begin
            valido_d = 1'b1;
            estado_d = MOVENDO;
            if (direcao_q && tem_acima) begin
              alvo_d = acima;
            end else if (tem_abaixo) begin
              alvo_d    = abaixo;
              direcao_d = 1'b0;
            end else begin
              alvo_d    = acima;
              direcao_d = 1'b1;
            end
          end
        end
      end
      MOVENDO: begin
        // Any pending floor reached en route is served, not only the target.
        if (aqui) begin
          limpa    = um_hot_atual;
          valido_d = 1'b0;
          cont_d   = RECARGA;
          estado_d = PORTA;
        end
      end
      PORTA: begin
        if (botoes_chamada[andar_atual]) begin
          cont_d = RECARGA;
        end else if (cont_q == 25'd0) begin
          estado_d = OCIOSO;
        end else begin
          cont_d = cont_q - 25'd1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // A press at the open door only extends the door; it never becomes a call.
  assign mascara     = (estado_q == PORTA) ? ~um_hot_atual : 4'b1111;
  assign pendentes_d = (pendentes_q | (botoes_chamada & mascara)) & ~limpa;

  always_comb begin
    alvo         = alvo_q;
    alvo_valido  = valido_q;
    pendentes    = pendentes_q;
    direcao      = direcao_q;
    porta_aberta = (estado_q == PORTA);
  end

endmodule

// File: tb/tb_despachante_chamadas.sv
// tb/tb_despachante_chamadas.sv - cycle-table and scoreboard bench for despachante_chamadas
module tb_despachante_chamadas;

  logic       clock_in;
  logic       reset_n;
  logic [3:0] botoes_chamada;
  logic [1:0] andar_atual;
  logic [1:0] alvo;
  logic       alvo_valido;
  logic [3:0] pendentes;
  logic       porta_aberta;
  logic       direcao;

  despachante_chamadas #(.TEMPO_PORTA(4)) dut (
    .clock_in       (clock_in),
    .reset_n        (reset_n),
    .botoes_chamada (botoes_chamada),
    .andar_atual    (andar_atual),
    .alvo           (alvo),
    .alvo_valido    (alvo_valido),
    .pendentes      (pendentes),
    .porta_aberta   (porta_aberta),
    .direcao        (direcao)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  typedef struct {
    logic       rst;
    logic [3:0] bot;
    logic [1:0] andar;
    logic [1:0] e_alvo;
    logic       e_valido;
    logic [3:0] e_pend;
    logic       e_porta;
    logic       e_dir;
    string      nome;
  } vetor_t;

  vetor_t vetores[$];
  vetor_t esperado[$];
  int checks = 0;
  int passed = 0;

  function automatic void add(input logic rst, input logic [3:0] bot, input logic [1:0] andar,
                              input logic [1:0] ea, input logic ev, input logic [3:0] ep,
                              input logic eo, input logic ed, input string nome);
    vetor_t v;
    v.rst = rst; v.bot = bot; v.andar = andar;
    v.e_alvo = ea; v.e_valido = ev; v.e_pend = ep; v.e_porta = eo; v.e_dir = ed;
    v.nome = nome;
    vetores.push_back(v);
  endfunction

  task automatic comparar(input string nome, input logic [1:0] ea, input logic ev,
                          input logic [3:0] ep, input logic eo, input logic ed);
    checks++;
    if (alvo === ea && alvo_valido === ev && pendentes === ep && porta_aberta === eo && direcao === ed) begin
      passed++;
    end else begin
      $display("FAIL %s: got alvo=%0d valido=%0b pend=%b porta=%0b dir=%0b, want alvo=%0d valido=%0b pend=%b porta=%0b dir=%0b",
               nome, alvo, alvo_valido, pendentes, porta_aberta, direcao, ea, ev, ep, eo, ed);
    end
  endtask

  task automatic aplicar(input int lo, input int hi);
    vetor_t v, e;
    for (int i = lo; i < hi; i++) begin
      @(negedge clock_in);
      v = vetores[i];
      reset_n        = v.rst;
      botoes_chamada = v.bot;
      andar_atual    = v.andar;
      esperado.push_back(v);
      @(posedge clock_in);
      #1;
      e = esperado.pop_front();
      comparar($sformatf("%s[%0d]", e.nome, i), e.e_alvo, e.e_valido, e.e_pend, e.e_porta, e.e_dir);
    end
  endtask

  int fim_viagem;

  initial begin
    // Simple trip 0 -> 3
    add(1, 4'b1000, 0, 0, 0, 4'b1000, 0, 1, "trip_latch");
    add(1, 4'b0000, 0, 3, 1, 4'b1000, 0, 1, "trip_dispatch");
    add(1, 4'b0000, 1, 3, 1, 4'b1000, 0, 1, "trip_pass1");
    add(1, 4'b0000, 3, 3, 0, 4'b0000, 1, 1, "trip_arrive");
    add(1, 4'b0000, 3, 3, 0, 4'b0000, 1, 1, "trip_door2");
    add(1, 4'b0000, 3, 3, 0, 4'b0000, 1, 1, "trip_door3");
    add(1, 4'b0000, 3, 3, 0, 4'b0000, 1, 1, "trip_door4");
    add(1, 4'b0000, 3, 3, 0, 4'b0000, 0, 1, "trip_close");
    // Intermediate stop at 2 on the way to 3
    add(1, 4'b1000, 0, 3, 0, 4'b1000, 0, 1, "mid_latch");
    add(1, 4'b0000, 0, 3, 1, 4'b1000, 0, 1, "mid_dispatch");
    add(1, 4'b0100, 1, 3, 1, 4'b1100, 0, 1, "mid_press2");
    add(1, 4'b0000, 2, 3, 0, 4'b1000, 1, 1, "mid_stop2");
    add(1, 4'b0000, 2, 3, 0, 4'b1000, 1, 1, "mid_door2");
    add(1, 4'b0000, 2, 3, 0, 4'b1000, 1, 1, "mid_door3");
    add(1, 4'b0000, 2, 3, 0, 4'b1000, 1, 1, "mid_door4");
    add(1, 4'b0000, 2, 3, 0, 4'b1000, 0, 1, "mid_close");
    add(1, 4'b0000, 2, 3, 1, 4'b1000, 0, 1, "mid_redispatch");
    add(1, 4'b0000, 3, 3, 0, 4'b0000, 1, 1, "mid_arrive3");
    add(1, 4'b0000, 3, 3, 0, 4'b0000, 1, 1, "mid_door_b2");
    add(1, 4'b0000, 3, 3, 0, 4'b0000, 1, 1, "mid_door_b3");
    add(1, 4'b0000, 3, 3, 0, 4'b0000, 1, 1, "mid_door_b4");
    add(1, 4'b0000, 3, 3, 0, 4'b0000, 0, 1, "mid_close_b");
    // Direction preference from floor 1 with calls at 0 and 3
    add(1, 4'b1001, 1, 3, 0, 4'b1001, 0, 1, "dir_latch");
    add(1, 4'b0000, 1, 3, 1, 4'b1001, 0, 1, "dir_up_first");
    add(1, 4'b0000, 2, 3, 1, 4'b1001, 0, 1, "dir_pass2");
    add(1, 4'b0000, 3, 3, 0, 4'b0001, 1, 1, "dir_arrive3");
    add(1, 4'b0000, 3, 3, 0, 4'b0001, 1, 1, "dir_door2");
    add(1, 4'b0000, 3, 3, 0, 4'b0001, 1, 1, "dir_door3");
    add(1, 4'b0000, 3, 3, 0, 4'b0001, 1, 1, "dir_door4");
    add(1, 4'b0000, 3, 3, 0, 4'b0001, 0, 1, "dir_close");
    add(1, 4'b0000, 3, 0, 1, 4'b0001, 0, 0, "dir_reverse");
    add(1, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, "dir_arrive0");
    add(1, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, "dir_door2");
    add(1, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, "dir_door3");
    add(1, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, "dir_door4");
    add(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, "dir_close");
    // Same-floor call at 2, re-pressed on the third door cycle
    add(1, 4'b0100, 2, 0, 0, 4'b0100, 0, 0, "same_latch");
    add(1, 4'b0000, 2, 0, 0, 4'b0000, 1, 0, "same_open");
    add(1, 4'b0000, 2, 0, 0, 4'b0000, 1, 0, "same_door2");
    add(1, 4'b0000, 2, 0, 0, 4'b0000, 1, 0, "same_door3");
    add(1, 4'b0100, 2, 0, 0, 4'b0000, 1, 0, "same_repress");
    add(1, 4'b0000, 2, 0, 0, 4'b0000, 1, 0, "same_ext2");
    add(1, 4'b0000, 2, 0, 0, 4'b0000, 1, 0, "same_ext3");
    add(1, 4'b0000, 2, 0, 0, 4'b0000, 1, 0, "same_ext4");
    add(1, 4'b0000, 2, 0, 0, 4'b0000, 0, 0, "same_close");
    // Arrival at 1 together with a floor 1 press: the clear wins
    add(1, 4'b0010, 3, 0, 0, 4'b0010, 0, 0, "clr_latch");
    add(1, 4'b0000, 3, 1, 1, 4'b0010, 0, 0, "clr_dispatch");
    add(1, 4'b0010, 1, 1, 0, 4'b0000, 1, 0, "clr_arrive_press");
    add(1, 4'b0000, 1, 1, 0, 4'b0000, 1, 0, "clr_door2");
    add(1, 4'b0000, 1, 1, 0, 4'b0000, 1, 0, "clr_door3");
    add(1, 4'b0000, 1, 1, 0, 4'b0000, 1, 0, "clr_door4");
    add(1, 4'b0000, 1, 1, 0, 4'b0000, 0, 0, "clr_close");
    // Into MOVENDO with pendentes=0110
    add(1, 4'b0110, 0, 1, 0, 4'b0110, 0, 0, "rst_latch");
    add(1, 4'b0000, 0, 1, 1, 4'b0110, 0, 1, "rst_dispatch");
    add(1, 4'b0000, 0, 1, 1, 4'b0110, 0, 1, "rst_moving");
    fim_viagem = vetores.size();
    // Reset held, then released: no dispatch afterwards
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, "rst_held");
    for (int k = 0; k < 6; k++)
      add(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, "rst_after");

    reset_n        = 1'b0;
    botoes_chamada = 4'b0000;
    andar_atual    = 2'd0;
    repeat (2) @(posedge clock_in);
    #1;
    comparar("reset_state", 0, 0, 4'b0000, 0, 1);

    aplicar(0, fim_viagem);

    // Mid-cycle asynchronous reset while in MOVENDO
    #2;
    reset_n = 1'b0;
    #1;
    comparar("async_reset", 0, 0, 4'b0000, 0, 1);

    aplicar(fim_viagem, vetores.size());

    if (esperado.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", esperado.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
